ifetch: RTL and testbench

Instruction-fetch stage of the RV32I core, directly downstream of the program counter register. Each cycle it takes the current PC, issues an instruction-memory read through a req/gnt request channel and an in-order rvalid response channel, and buffers returned instructions with their PC in a small FIFO. Decode drains the FIFO with a valid/ready handshake. On a taken jump/branch (redirect) the block discards all in-flight and buffered fetches, and it tells the PC register when to hold.

---
 rtl/ifetch_if.sv | 63 ++++++
 rtl/ifetch.sv | 230 +++++++++++++++++++++++
 tb/tb_ifetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_if
//
// Bundles the two handshake channels of the instruction-fetch stage:
//   - instruction memory: imem_req/imem_addr/imem_gnt form the request
//     channel, and imem_rvalid/imem_rdata/imem_err form the in-order
//     response channel.
//   - decode: dec_valid/dec_pc/dec_instr/dec_exc/dec_ready.
//
// Handshake semantics:
//   A request transfers on a rising edge where imem_req && imem_gnt. The
//   response channel has no ready signal: every imem_rvalid is consumed on
//   the edge it is seen, and responses arrive in request order. A decode
//   transfer happens on an edge where dec_valid && dec_ready. The fetch
//   stage holds dec_* stable while dec_valid=1 and dec_ready=0, except that
//   a redirect discards the head.
//
// Modports:
//   master - the fetch stage (drives imem_req/imem_addr and dec_*).
//   slave  - the memory/decode environment.
// ---------------------------------------------------------------------------
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [1:0]  dec_exc;
  logic        dec_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  imem_err,
    output dec_valid,
    output dec_pc,
    output dec_instr,
    output dec_exc,
    input  dec_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output imem_err,
    input  dec_valid,
    input  dec_pc,
    input  dec_instr,
    input  dec_exc,
    output dec_ready
  );
endinterface

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch
//
// Instruction-fetch stage of the RV32I core. Each cycle it may issue a read
// of the current PC to instruction memory, tracks every outstanding read in
// a small pending queue, and writes returned instructions (with their PC and
// an exception code) into an instruction buffer that decode drains.
// A redirect (taken jump/branch) empties the buffer and marks every read
// still in flight as to-be-discarded.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   pc_i      in   fetch address from the PC register
//   redirect  in   PC register jump enable; flushes this stage
//   pc_hold   out  PC register must keep its current value
//   bus       ifetch_if.master: instruction memory request/response and
//             decode valid/ready channels
//
// Parameter:
//   FIFO_DEPTH  buffer entries (power of two, >= 2). Also bounds the number
//               of reads in flight, because each read reserves a buffer slot.
//
// dec_exc encoding: 00 none, 01 bus error, 10 misaligned PC.
// ---------------------------------------------------------------------------
module ifetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        redirect,
  output logic        pc_hold,
  ifetch_if.master    bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_BUS  = 2'b01;
  localparam logic [1:0] EXC_MIS  = 2'b10;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  // One outstanding read: the PC it was issued for and whether that PC was
  // misaligned (the bus only ever sees the word-aligned address).
  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
  } pend_t;

  // One buffered instruction as presented to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  exc;
  } entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  pend_t  pend_q [FIFO_DEPTH];
  pend_t  pend_d [FIFO_DEPTH];
  ptr_t   pend_wr_q, pend_wr_d;
  ptr_t   pend_rd_q, pend_rd_d;
  cnt_t   outst_q, outst_d;
  cnt_t   discard_q, discard_d;

  entry_t fifo_q [FIFO_DEPTH];
  entry_t fifo_d [FIFO_DEPTH];
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  cnt_t   count_q, count_d;

  // ---------------------------------------------------------------------
  // Request channel (combinational from registered counts, pc_i, redirect)
  // ---------------------------------------------------------------------
  logic [CW:0] in_use;
  logic        issue_ok;
  logic        accept;

  // Reads in flight plus buffered entries; a new read is only issued when
  // it can be guaranteed a buffer slot, so responses never stall.
  assign in_use   = {1'b0, outst_q} + {1'b0, count_q};
  assign issue_ok = (in_use < DEPTH_V);

  assign bus.imem_req  = reset && !redirect && issue_ok;
  assign bus.imem_addr = {pc_i[31:2], 2'b00};
  assign accept        = bus.imem_req && bus.imem_gnt;

  // Hold the PC until its read is accepted. During reset the PC is held
  // regardless of redirect.
  assign pc_hold = !reset || (!redirect && !accept);

  // ---------------------------------------------------------------------
  // Response / buffer control
  // ---------------------------------------------------------------------
  logic   resp;
  logic   push;
  logic   pop;
  pend_t  resp_pend;
  entry_t resp_entry;

  // An rvalid with nothing outstanding is stale (e.g. from before a reset)
  // and is ignored entirely.
  assign resp      = bus.imem_rvalid && (outst_q != '0);
  assign resp_pend = pend_q[pend_rd_q];

  // A response is buffered only if it belongs to the current fetch stream:
  // not marked for discard and not arriving during a redirect.
  assign push = resp && (discard_q == '0) && !redirect;
  assign pop  = (count_q != '0) && bus.dec_ready && !redirect;

  always_comb begin
    resp_entry       = '0;
    resp_entry.pc    = resp_pend.pc;
    resp_entry.instr = bus.imem_rdata;
    // A misaligned PC outranks a bus error on the same fetch.
    if (resp_pend.mis) begin
      resp_entry.exc = EXC_MIS;
    end else if (bus.imem_err) begin
      resp_entry.exc = EXC_BUS;
    end else begin
      resp_entry.exc = EXC_NONE;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Pending queue: push on accept, pop on every consumed response. It is
    // deliberately not flushed on redirect; discarded reads still return and
    // must still pop their entry.
    if (accept) begin
      pend_d[pend_wr_q].pc  = pc_i;
      pend_d[pend_wr_q].mis = (pc_i[1:0] != 2'b00);
      pend_wr_d             = pend_wr_q + 1'b1;
    end
    if (resp) begin
      pend_rd_d = pend_rd_q + 1'b1;
    end

    if (accept && !resp) begin
      outst_d = outst_q + 1'b1;
    end else if (!accept && resp) begin
      outst_d = outst_q - 1'b1;
    end

    if (redirect) begin
      // Everything still in flight after this cycle belongs to the old
      // stream. No read is accepted on a redirect cycle, so outst_d is
      // exactly the number of reads left to drop.
      discard_d = outst_d;
      count_d   = '0;
      head_d    = tail_q;
    end else begin
      if (resp && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end

      if (push) begin
        fifo_d[tail_q] = resp_entry;
        tail_d         = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end

      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pend_q[i] <= '0;
        fifo_q[i] <= '0;
      end
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Decode outputs: straight from buffer registers, so there is no
  // combinational path from imem_rdata to dec_*. Buffer storage resets to
  // zero, which gives dec_pc/dec_instr/dec_exc = 0 out of reset.
  // ---------------------------------------------------------------------
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_pc    = fifo_q[head_q].pc;
  assign bus.dec_instr = fifo_q[head_q].instr;
  assign bus.dec_exc   = fifo_q[head_q].exc;

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch
//
// Drives the fetch stage one cycle at a time. A reference model built from
// plain queues (outstanding reads, buffered instructions, a discard count)
// predicts the request-channel outputs and the decode head every cycle.
// Directed phases cover streaming, back-pressure, redirects, errors, slow
// memory and reset mid-fetch; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ifetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        redirect;
  logic        pc_hold;

  ifetch_if bus_if ();

  ifetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_i     (pc_i),
    .redirect (redirect),
    .pc_hold  (pc_hold),
    .bus      (bus_if)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  logic [32:0] pend_q[$];   // {misaligned, pc} per outstanding read
  logic [65:0] exp_q[$];    // {exc, instr, pc} per buffered instruction
  int          discard;
  logic [31:0] pc_reg;      // bench-side PC register

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then advance the model at the rising edge.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit gnt,
                      input bit rv, input bit err, input bit rdy);
    bit          exp_req;
    bit          exp_hold;
    bit          accept;
    bit          resp;
    bit          pop;
    logic [32:0] head;
    logic [31:0] rdata;
    logic [1:0]  exc;

    redirect            = redir;
    pc_i                = pc_reg;
    bus_if.imem_gnt     = gnt;
    bus_if.imem_rvalid  = rv;
    bus_if.imem_err     = err;
    bus_if.dec_ready    = rdy;
    rdata               = (pend_q.size() > 0) ? (32'h13 + pend_q[0][31:0]) : $urandom;
    bus_if.imem_rdata   = rdata;

    @(negedge clk);
    exp_req  = !redir && ((pend_q.size() + exp_q.size()) < DEPTH);
    exp_hold = !redir && !(exp_req && gnt);
    check("imem_req", bus_if.imem_req, exp_req);
    check("imem_addr", bus_if.imem_addr, {pc_reg[31:2], 2'b00});
    check("pc_hold", pc_hold, exp_hold);
    check("dec_valid", bus_if.dec_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("dec_pc", bus_if.dec_pc, exp_q[0][31:0]);
      check("dec_instr", bus_if.dec_instr, exp_q[0][63:32]);
      check("dec_exc", bus_if.dec_exc, exp_q[0][65:64]);
    end

    @(posedge clk);
    accept = exp_req && gnt;
    resp   = rv && (pend_q.size() > 0);
    pop    = !redir && rdy && (exp_q.size() > 0);
    if (pop) void'(exp_q.pop_front());
    if (resp) begin
      head = pend_q.pop_front();
      exc  = head[32] ? 2'b10 : (err ? 2'b01 : 2'b00);
      if (!redir) begin
        if (discard > 0) discard--;
        else exp_q.push_back({exc, rdata, head[31:0]});
      end
    end
    if (redir) begin
      exp_q.delete();
      discard = pend_q.size();
    end
    if (accept) pend_q.push_back({pc_reg[1:0] != 2'b00, pc_reg});
    if (redir) pc_reg = tgt;
    else if (!exp_hold) pc_reg = pc_reg + 32'd4;
    #1;
  endtask

  // Assert reset, check reset outputs, release away from the clock edge.
  task automatic do_reset(input logic [31:0] start_pc);
    reset              = 1'b0;
    redirect           = 1'b0;
    bus_if.imem_gnt    = 1'b0;
    bus_if.imem_rvalid = 1'b0;
    bus_if.imem_err    = 1'b0;
    bus_if.dec_ready   = 1'b0;
    bus_if.imem_rdata  = '0;
    #1;
    check("rst_imem_req", bus_if.imem_req, 1'b0);
    check("rst_pc_hold", pc_hold, 1'b1);
    check("rst_dec_valid", bus_if.dec_valid, 1'b0);
    check("rst_dec_pc", bus_if.dec_pc, 32'h0);
    check("rst_dec_instr", bus_if.dec_instr, 32'h0);
    check("rst_dec_exc", bus_if.dec_exc, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pend_q.delete();
    exp_q.delete();
    discard = 0;
    pc_reg  = start_pc;
    pc_i    = start_pc;
  endtask

  initial begin
    bit          r_redir;
    bit          r_gnt;
    bit          r_rv;
    bit          r_err;
    bit          r_rdy;
    logic [31:0] r_tgt;

    pc_reg  = 32'h0;
    pc_i    = 32'h0;
    discard = 0;

    // Reset at time zero
    do_reset(32'h0);

    // Streaming: gnt every cycle, rvalid the cycle after each grant
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b1, pend_q.size() > 0, 1'b0, 1'b1);
      if (i == 1) begin
        check("stream_first_valid", bus_if.dec_valid, 1'b1);
        check("stream_first_pc", bus_if.dec_pc, 32'h0);
        check("stream_first_instr", bus_if.dec_instr, 32'h13);
      end
    end

    // Back-pressure: decode stalls, issue stops after the buffer reservation fills
    do_reset(32'h200);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, pend_q.size() > 0, 1'b0, 1'b0);
    check("bp_req_low", bus_if.imem_req, 1'b0);
    check("bp_hold", pc_hold, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, pend_q.size() > 0, 1'b0, 1'b1);

    // Redirect with two reads in flight
    do_reset(32'h300);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("redir_dropped", bus_if.dec_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("redir_new_valid", bus_if.dec_valid, 1'b1);
    check("redir_new_pc", bus_if.dec_pc, 32'h100);

    // Redirect coincident with a response
    do_reset(32'h400);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h180, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("coinc_dropped", bus_if.dec_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("coinc_new_pc", bus_if.dec_pc, 32'h180);

    // Misaligned PC outranks a bus error
    do_reset(32'h102);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("mis_pc", bus_if.dec_pc, 32'h102);
    check("mis_exc", bus_if.dec_exc, 2'b10);

    // Bus error on an aligned fetch
    do_reset(32'h500);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("err_pc", bus_if.dec_pc, 32'h500);
    check("err_exc", bus_if.dec_exc, 2'b01);

    // Slow memory: grant delayed 3 cycles, responses delayed 5 cycles
    do_reset(32'h600);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("slow_addr", bus_if.imem_addr, 32'h600);
    check("slow_hold", pc_hold, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("slow_order_pc", bus_if.dec_pc, 32'h604);
    check("slow_order_instr", bus_if.dec_instr, 32'h617);

    // Reset mid-fetch with one read outstanding, then a stray response
    do_reset(32'h700);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_reset(32'h900);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("stray_ignored", bus_if.dec_valid, 1'b0);

    // Randomized traffic
    do_reset(32'h800);
    for (int n = 0; n < 800; n++) begin
      r_redir = ($urandom_range(0, 15) == 0);
      r_tgt   = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 7) == 0) r_tgt[1:0] = 2'($urandom_range(1, 3));
      r_gnt   = ($urandom_range(0, 1) == 1);
      r_rv    = (pend_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      r_err   = ($urandom_range(0, 7) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      step(r_redir, r_tgt, r_gnt, r_rv, r_err, r_rdy);
      if ($urandom_range(0, 149) == 0) do_reset(32'($urandom_range(0, 255)) << 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
